num_ascii_streamer: RTL

- Converts an unsigned binary value of WIDTH bits into a multi-digit decimal ASCII byte stream, most significant digit first.
- Optionally appends a CR LF terminator.
- Generalises the single-digit ASCII encoder: parametrised digit count, iterative double-dabble conversion, leading-zero handling modes, and valid/ready handshakes on both sides.
- Sits between telemetry sources (servo angles, sensor counts) and the UART transmitter on the biped controller.

---
 rtl/ascii_pkg.sv | 30 +++
 rtl/num_ascii_streamer_if.sv | 22 ++
 rtl/ascii_digit_lut.sv | 15 +
 rtl/num_ascii_streamer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ascii_pkg.sv
// Shared ASCII constants, converter state encoding and leading-zero modes
// for the decimal ASCII streamer.
package ascii_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'd48;
    localparam logic [7:0] ASCII_SPACE = 8'd32;
    localparam logic [7:0] ASCII_CR    = 8'd13;
    localparam logic [7:0] ASCII_LF    = 8'd10;

    localparam int LZ_ZERO  = 0;
    localparam int LZ_SPACE = 1;
    localparam int LZ_OMIT  = 2;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        EMIT,
        TERM
    } state_t;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/num_ascii_streamer_if.sv
// Value-in / byte-out handshake bundle of the decimal ASCII streamer.
interface num_ascii_streamer_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_value;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_last;

    modport master (
        output in_valid, in_value, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_value, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/ascii_digit_lut.sv
// Combinational BCD digit to ASCII character; non-decimal codes map to space.
module ascii_digit_lut
    import ascii_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] ascii
);
    always_comb begin
        if (digit <= 4'd9) begin
            ascii = ASCII_ZERO + {4'd0, digit};
        end else begin
            ascii = ASCII_SPACE;
        end
    end
endmodule

// File: rtl/num_ascii_streamer.sv
// Unsigned binary to decimal ASCII byte stream, MSD first, via iterative
// double-dabble, with selectable leading-zero handling and optional CR LF.
module num_ascii_streamer
    import ascii_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NDIGITS = 5,
    parameter int LZ_MODE = 1,
    parameter int TERM_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    num_ascii_streamer_if.slave io,
    output logic               busy
);
    localparam int BCD_W = 4 * NDIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    localparam longint unsigned MAX_DEC = pow10(NDIGITS) - 64'd1;
    localparam longint unsigned MAX_BIN = (64'd1 << WIDTH) - 64'd1;

    if (MAX_DEC < MAX_BIN) begin : g_ndigits_err
        $error("num_ascii_streamer: NDIGITS too small to hold 2^WIDTH-1");
    end
    if (LZ_MODE != LZ_ZERO && LZ_MODE != LZ_SPACE && LZ_MODE != LZ_OMIT) begin : g_lzmode_err
        $error("num_ascii_streamer: unsupported LZ_MODE");
    end

    state_t             state;
    logic [BCD_W-1:0]   bcd;
    logic [WIDTH-1:0]   shift;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic               digits_done;
    logic               term_lf;
    logic               out_valid_r;
    logic [7:0]         out_data_r;
    logic               out_last_r;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_upper;
    logic [3:0]         digit_sel;
    logic [7:0]         digit_ascii;
    logic [7:0]         emit_byte;
    logic               lead;
    logic               skip;
    logic               load_ok;

    // Add-3 correction applied to every BCD digit of 5 or more before the shift.
    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < NDIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign bcd_adj = dabble_adj(bcd);

    // A digit is leading when it and every more-significant digit are zero;
    // the units digit never is, so zero still prints as "0".
    always_comb begin
        digit_sel = bcd[4*int'(idx) +: 4];
        bcd_upper = bcd >> (4 * int'(idx));
        lead      = (idx != '0) && (bcd_upper == '0);
    end

    ascii_digit_lut u_lut (
        .digit (digit_sel),
        .ascii (digit_ascii)
    );

    always_comb begin
        emit_byte = digit_ascii;
        if (lead && (LZ_MODE == LZ_SPACE)) begin
            emit_byte = ASCII_SPACE;
        end
    end

    assign skip    = lead && (LZ_MODE == LZ_OMIT);
    // The output register may be reloaded when empty or being consumed this cycle.
    assign load_ok = !out_valid_r || io.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bcd         <= '0;
            shift       <= '0;
            cnt         <= '0;
            idx         <= '0;
            digits_done <= 1'b0;
            term_lf     <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        shift <= io.in_value;
                        bcd   <= '0;
                        cnt   <= CNT_W'(WIDTH);
                        state <= CONV;
                    end
                end

                CONV: begin
                    bcd   <= {bcd_adj[BCD_W-2:0], shift[WIDTH-1]};
                    shift <= {shift[WIDTH-2:0], 1'b0};
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        idx         <= IDX_W'(NDIGITS - 1);
                        digits_done <= 1'b0;
                        state       <= EMIT;
                    end
                end

                EMIT: begin
                    if (load_ok) begin
                        if (digits_done) begin
                            if (TERM_EN != 0) begin
                                out_data_r  <= ASCII_CR;
                                out_valid_r <= 1'b1;
                                out_last_r  <= 1'b0;
                                term_lf     <= 1'b0;
                                state       <= TERM;
                            end else begin
                                out_valid_r <= 1'b0;
                                out_last_r  <= 1'b0;
                                state       <= IDLE;
                            end
                        end else if (skip) begin
                            idx <= idx - IDX_W'(1);
                        end else begin
                            out_data_r  <= emit_byte;
                            out_valid_r <= 1'b1;
                            out_last_r  <= (idx == '0) && (TERM_EN == 0);
                            if (idx == '0) begin
                                digits_done <= 1'b1;
                            end else begin
                                idx <= idx - IDX_W'(1);
                            end
                        end
                    end
                end

                TERM: begin
                    if (load_ok) begin
                        if (!term_lf) begin
                            out_data_r <= ASCII_LF;
                            out_last_r <= 1'b1;
                            term_lf    <= 1'b1;
                        end else begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = out_valid_r;
    assign io.out_data  = out_data_r;
    assign io.out_last  = out_last_r;
    assign busy         = (state != IDLE);

endmodule
